// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - lock-and-verify checker for a free-running counter stream
// Optional capture of the first locked mismatch: COUNT_SEQ_CHECKER_CAPTURE_EN
module count_seq_checker #(
  parameter int WIDTH      = 8,
  parameter int STEP       = 1,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 locked,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count,
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
  output logic [WIDTH-1:0]     first_bad,
  output logic                 first_bad_valid,
`endif
  output logic [WIDTH-1:0]     expected
);

  localparam int GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int BW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;
  localparam logic [WIDTH-1:0]     STEP_W    = WIDTH'(STEP);
  localparam logic [GW-1:0]        GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0]        BAD_LAST  = BW'(LOSS_COUNT - 1);
  localparam logic [GW-1:0]        GOOD_ONE  = GW'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;

  state_t                 state, state_n;
  logic [GW-1:0]          good_run, good_run_n;
  logic [BW-1:0]          bad_run, bad_run_n;
  logic [WIDTH-1:0]       expected_n;
  logic                   locked_n, mismatch_n;
  logic [ERR_CNT_W-1:0]   err_count_n;

  logic                   hit;
  logic [WIDTH-1:0]       seed_exp, fwd_exp;
  logic [ERR_CNT_W-1:0]   err_inc;

  assign hit      = (in_data == expected);
  assign seed_exp = in_data + STEP_W;
  assign fwd_exp  = expected + STEP_W;
  assign err_inc  = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;

`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
  logic [WIDTH-1:0] first_bad_n;
  logic             first_bad_valid_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    good_run_n  = good_run;
    bad_run_n   = bad_run;
    expected_n  = expected;
    err_count_n = err_count;
    mismatch_n  = 1'b0;
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    first_bad_n       = first_bad;
    first_bad_valid_n = first_bad_valid;
`endif
    if (in_valid) begin
      case (state)
        IDLE: begin
          expected_n = seed_exp;
          good_run_n = GOOD_ONE;
          state_n    = (LOCK_COUNT == 1) ? LOCKED : SEARCH;
        end
        SEARCH: begin
          // Resync on every sample; a miss simply restarts the run with a new seed.
          expected_n = seed_exp;
          if (hit) begin
            good_run_n = good_run + 1'b1;
            if (good_run >= GOOD_LAST) state_n = LOCKED;
          end else begin
            good_run_n = GOOD_ONE;
            if (LOCK_COUNT == 1) state_n = LOCKED;
          end
        end
        LOCKED: begin
          expected_n = fwd_exp;
          if (hit) begin
            bad_run_n = '0;
          end else begin
            mismatch_n  = 1'b1;
            err_count_n = err_inc;
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
            if (!first_bad_valid) begin
              first_bad_n       = in_data;
              first_bad_valid_n = 1'b1;
            end
`endif
            if (bad_run >= BAD_LAST) begin
              state_n    = SEARCH;
              expected_n = seed_exp;
              good_run_n = GOOD_ONE;
              bad_run_n  = '0;
            end else begin
              bad_run_n = bad_run + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
    locked_n = (state_n == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      good_run  <= '0;
      bad_run   <= '0;
      expected  <= '0;
      err_count <= '0;
      mismatch  <= 1'b0;
      locked    <= 1'b0;
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
      first_bad       <= '0;
      first_bad_valid <= 1'b0;
`endif
    end else begin
      good_run  <= good_run_n;
      bad_run   <= bad_run_n;
      expected  <= expected_n;
      err_count <= err_count_n;
      mismatch  <= mismatch_n;
      locked    <= locked_n;
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
      first_bad       <= first_bad_n;
      first_bad_valid <= first_bad_valid_n;
`endif
    end
  end

endmodule

// File: tb/tb_count_seq_checker.sv
// tb/tb_count_seq_checker.sv - scoreboard bench for count_seq_checker
// Optional capture checks follow COUNT_SEQ_CHECKER_CAPTURE_EN.
module tb_count_seq_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        locked, mismatch;
  logic [15:0] err_count;
  logic [7:0]  expected;
  logic        locked6, mismatch6;
  logic [1:0]  err_count6;
  logic [7:0]  expected6;
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
  logic [7:0]  first_bad, first_bad6;
  logic        first_bad_valid, first_bad_valid6;
`endif

  always #5 clk = ~clk;

  count_seq_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .mismatch(mismatch), .err_count(err_count),
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    .first_bad(first_bad), .first_bad_valid(first_bad_valid),
`endif
    .expected(expected)
  );

  count_seq_checker #(.ERR_CNT_W(2), .LOSS_COUNT(8)) dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .locked(locked6), .mismatch(mismatch6), .err_count(err_count6),
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    .first_bad(first_bad6), .first_bad_valid(first_bad_valid6),
`endif
    .expected(expected6)
  );

  // Record layout: {locked, mismatch, err_count[15:0], expected[7:0]}
  logic [25:0] exp_q[$];
  logic [25:0] obs_q[$];
  logic        sel6 = 1'b0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic send(input logic r, input logic v, input logic [7:0] d,
                      input logic l, input logic m, input logic [15:0] er, input logic [7:0] ex);
    rst = r; in_valid = v; in_data = d;
    exp_q.push_back({l, m, er, ex});
    @(posedge clk); #1;
    obs_q.push_back(sel6 ? {locked6, mismatch6, 14'd0, err_count6, expected6}
                         : {locked, mismatch, err_count, expected});
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic lock_from(input logic [7:0] base);
    send(1, 0, 8'h00, 0, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++)
      send(0, 1, base + 8'(i), i == 3, 0, 0, base + 8'(i + 1));
  endtask

  task automatic test_reset;
    send(1, 0, 8'h00, 0, 0, 0, 8'h00);
    send(1, 1, 8'h37, 0, 0, 0, 8'h00);
    send(0, 0, 8'h37, 0, 0, 0, 8'h00);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [25:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL reset[%0d] got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_basic_lock;
    send(1, 0, 8'h00, 0, 0, 0, 8'h00);
    for (int i = 0; i < 6; i++)
      send(0, 1, 8'(i), i >= 3, 0, 0, 8'(i + 1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [25:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL basic_lock[%0d] got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_wrap;
    lock_from(8'hFC);
    send(0, 1, 8'h00, 1, 0, 0, 8'h01);
    send(0, 1, 8'h01, 1, 0, 0, 8'h02);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [25:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL wrap[%0d] got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_single_miss;
    lock_from(8'h0D);
    send(0, 1, 8'h55, 1, 1, 1, 8'h12);
    send(0, 1, 8'h12, 1, 0, 1, 8'h13);
    send(0, 1, 8'h77, 1, 1, 2, 8'h14);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [25:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL single_miss[%0d] got %h want %h", i, o, e); end
    end
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    n_cmp++;
    if ({first_bad_valid, first_bad} !== 9'h155) begin
      n_fail++; $display("FAIL capture_first got %h want %h", {first_bad_valid, first_bad}, 9'h155);
    end
`endif
  endtask

  task automatic test_loss_relock;
    lock_from(8'h0D);
    send(0, 1, 8'h55, 1, 1, 1, 8'h12);
    send(0, 1, 8'h66, 0, 1, 2, 8'h67);
    send(0, 1, 8'h67, 0, 0, 2, 8'h68);
    send(0, 1, 8'h68, 0, 0, 2, 8'h69);
    send(0, 1, 8'h69, 1, 0, 2, 8'h6A);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [25:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL loss_relock[%0d] got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_gaps_and_reset;
    lock_from(8'h1D);
    for (int i = 0; i < 3; i++) send(0, 0, 8'hEE, 1, 0, 0, 8'h21);
    send(0, 1, 8'h21, 1, 0, 0, 8'h22);
    send(0, 1, 8'h99, 1, 1, 1, 8'h23);
    send(0, 0, 8'h23, 1, 0, 1, 8'h23);
    send(1, 1, 8'h23, 0, 0, 0, 8'h00);
    send(0, 1, 8'h40, 0, 0, 0, 8'h41);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [25:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL gaps_reset[%0d] got %h want %h", i, o, e); end
    end
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    n_cmp++;
    if ({first_bad_valid, first_bad} !== 9'h000) begin
      n_fail++; $display("FAIL capture_reset got %h want %h", {first_bad_valid, first_bad}, 9'h000);
    end
`endif
  endtask

  task automatic test_saturate;
    sel6 = 1'b1;
    lock_from(8'h00);
    for (int i = 0; i < 5; i++)
      send(0, 1, 8'hA0 + 8'(i), 1, 1, (i >= 2) ? 16'd3 : 16'(i + 1), 8'(i + 5));
    sel6 = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [25:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL saturate[%0d] got %h want %h", i, o, e); end
    end
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    n_cmp++;
    if ({first_bad_valid6, first_bad6} !== 9'h1A0) begin
      n_fail++; $display("FAIL capture_sat got %h want %h", {first_bad_valid6, first_bad6}, 9'h1A0);
    end
`endif
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset;
    test_basic_lock;
    test_wrap;
    test_single_miss;
    test_loss_relock;
    test_gaps_and_reset;
    test_saturate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
